// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controllers: op encodings,
// multiplier signedness selects and the issue-controller state encoding.
package mdu_pkg;

    // RV64M multiply op encodings as presented on ex_op
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_MULW   = 3'd4;

    // Multiplier signedness: bit1 = multiplicand signed, bit0 = multiplier signed
    localparam logic [1:0] MUL_SIGNED_SS = 2'b11;
    localparam logic [1:0] MUL_SIGNED_SU = 2'b10;
    localparam logic [1:0] MUL_SIGNED_UU = 2'b00;

    // Issue controller FSM state encoding
    typedef logic [2:0] mul_state_t;
    localparam mul_state_t MUL_ST_IDLE  = 3'd0;
    localparam mul_state_t MUL_ST_REQ   = 3'd1;
    localparam mul_state_t MUL_ST_WAIT  = 3'd2;
    localparam mul_state_t MUL_ST_DONE  = 3'd3;
    localparam mul_state_t MUL_ST_DRAIN = 3'd4;

    // Unused op codes 5-7 behave exactly like MUL
    function automatic logic [2:0] mdu_norm_op(input logic [2:0] op);
        return (op > MDU_MULW) ? MDU_MUL : op;
    endfunction

    // Signedness select for a normalised multiply op
    function automatic logic [1:0] mul_signed_of(input logic [2:0] op);
        case (op)
            MDU_MULHSU: return MUL_SIGNED_SU;
            MDU_MULHU:  return MUL_SIGNED_UU;
            default:    return MUL_SIGNED_SS;
        endcase
    endfunction

endpackage

// File: rtl/mul_result_fmt.sv
// Picks the architectural result out of a full hi/lo product and applies
// the 32-bit sign extension used by the word-sized ops.
module mul_result_fmt
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] data
);

    // High-half ops take hi, MULW sign-extends the low word, everything else takes lo
    always_comb begin
        data = lo;
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_MULHU: data = hi;
            MDU_MULW: data = {{(XLEN-32){lo[31]}}, lo[31:0]};
            default:  data = lo;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage controller for the radix-4 Booth multiplier: accepts one
// multiply uop, issues it, captures the result pulse, formats it and holds it
// for writeback. Zero operands skip the multiplier; a flush while the
// multiplier is busy drains its stale result pulse.
module mul_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic            m_in_valid,
    input  logic            m_out_ready,
    output logic            m_flush,
    output logic            m_mulw,
    output logic [1:0]      m_mul_signed,
    output logic [XLEN-1:0] m_multiplicand,
    output logic [XLEN-1:0] m_multiplier,
    input  logic            m_out_valid,
    input  logic [XLEN-1:0] m_result_hi,
    input  logic [XLEN-1:0] m_result_lo
);

    mul_state_t      state;
    logic [2:0]      op_q;
    logic [2:0]      op_norm;
    logic [XLEN-1:0] src1_ext;
    logic [XLEN-1:0] src2_ext;
    logic [XLEN-1:0] fmt_data;
    logic [XLEN-1:0] wb_data_q;
    logic            accept;
    logic            zero_operand;

    // Normalise the incoming op and sign-extend word operands before latching
    always_comb begin
        op_norm  = mdu_norm_op(ex_op);
        src1_ext = ex_src1;
        src2_ext = ex_src2;
        if (op_norm == MDU_MULW) begin
            src1_ext = {{(XLEN-32){ex_src1[31]}}, ex_src1[31:0]};
            src2_ext = {{(XLEN-32){ex_src2[31]}}, ex_src2[31:0]};
        end
    end

    assign accept       = ex_valid & (state == MUL_ST_IDLE) & ~flush;
    assign zero_operand = (src1_ext == '0) | (src2_ext == '0);

    assign ex_ready   = (state == MUL_ST_IDLE);
    assign wb_valid   = (state == MUL_ST_DONE);
    assign wb_data    = wb_data_q;
    assign m_in_valid = (state == MUL_ST_REQ) & m_out_ready & ~flush;
    assign m_flush    = flush;

    mul_result_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .op   (op_q),
        .hi   (m_result_hi),
        .lo   (m_result_lo),
        .data (fmt_data)
    );

    // Latch the op, its multiplier controls and both operands on accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q           <= MDU_MUL;
            m_mulw         <= 1'b0;
            m_mul_signed   <= 2'b00;
            m_multiplicand <= '0;
            m_multiplier   <= '0;
        end else if (accept) begin
            op_q           <= op_norm;
            m_mulw         <= (op_norm == MDU_MULW);
            m_mul_signed   <= mul_signed_of(op_norm);
            m_multiplicand <= src1_ext;
            m_multiplier   <= src2_ext;
        end
    end

    // Sequence one uop through issue, wait, writeback and flush drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= MUL_ST_IDLE;
        end else begin
            case (state)
                MUL_ST_IDLE: begin
                    if (accept) begin
                        state <= zero_operand ? MUL_ST_DONE : MUL_ST_REQ;
                    end
                end
                MUL_ST_REQ: begin
                    if (flush) begin
                        state <= MUL_ST_IDLE;
                    end else if (m_out_ready) begin
                        state <= MUL_ST_WAIT;
                    end
                end
                MUL_ST_WAIT: begin
                    if (m_out_valid) begin
                        state <= flush ? MUL_ST_IDLE : MUL_ST_DONE;
                    end else if (flush) begin
                        state <= MUL_ST_DRAIN;
                    end
                end
                MUL_ST_DONE: begin
                    if (flush || wb_ready) begin
                        state <= MUL_ST_IDLE;
                    end
                end
                MUL_ST_DRAIN: begin
                    if (m_out_valid) begin
                        state <= MUL_ST_IDLE;
                    end
                end
                default: state <= MUL_ST_IDLE;
            endcase
        end
    end

    // Register the writeback value: zero for bypassed ops, formatted product otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_data_q <= '0;
        end else if (accept && zero_operand) begin
            wb_data_q <= '0;
        end else if ((state == MUL_ST_WAIT) && m_out_valid && !flush) begin
            wb_data_q <= fmt_data;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural multiplier that
// answers after a programmable latency and a spec-level result model.
module tb_mul_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [63:0] ex_src1;
    logic [63:0] ex_src2;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic        m_in_valid;
    logic        m_out_ready;
    logic        m_flush;
    logic        m_mulw;
    logic [1:0]  m_mul_signed;
    logic [63:0] m_multiplicand;
    logic [63:0] m_multiplier;
    logic        m_out_valid;
    logic [63:0] m_result_hi;
    logic [63:0] m_result_lo;

    int assertions_evaluated = 0;
    int failures = 0;
    int mul_latency = 34;
    int m_in_count = 0;

    mul_issue_ctrl #(.XLEN(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_op          (ex_op),
        .ex_src1        (ex_src1),
        .ex_src2        (ex_src2),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .m_in_valid     (m_in_valid),
        .m_out_ready    (m_out_ready),
        .m_flush        (m_flush),
        .m_mulw         (m_mulw),
        .m_mul_signed   (m_mul_signed),
        .m_multiplicand (m_multiplicand),
        .m_multiplier   (m_multiplier),
        .m_out_valid    (m_out_valid),
        .m_result_hi    (m_result_hi),
        .m_result_lo    (m_result_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural multiplier: full 128-bit product after mul_latency cycles,
    // random junk on the result buses whenever no pulse is present
    logic [127:0] pend_prod;
    int           pend_cnt = 0;
    always @(posedge clock) begin
        logic [127:0] ax, bx;
        m_out_valid <= 1'b0;
        m_result_hi <= {$urandom, $urandom};
        m_result_lo <= {$urandom, $urandom};
        if (reset) begin
            pend_cnt = 0;
        end else if (m_in_valid) begin
            m_in_count++;
            ax = {{64{m_multiplicand[63] & m_mul_signed[1]}}, m_multiplicand};
            bx = {{64{m_multiplier[63] & m_mul_signed[0]}}, m_multiplier};
            pend_prod = ax * bx;
            pend_cnt = mul_latency;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                m_out_valid <= 1'b1;
                m_result_hi <= pend_prod[127:64];
                m_result_lo <= pend_prod[63:0];
            end
        end
    end

    // Architectural RV64M result computed directly from the source registers
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  w;
        case (op)
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            3'd4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
            default: return a * b;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions_evaluated++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ex_ready"},       64'(ex_ready), 64'd1);
        checkOutput({tag, "_wb_valid"},       64'(wb_valid), 64'd0);
        checkOutput({tag, "_wb_data"},        wb_data, 64'd0);
        checkOutput({tag, "_m_in_valid"},     64'(m_in_valid), 64'd0);
        checkOutput({tag, "_m_mulw"},         64'(m_mulw), 64'd0);
        checkOutput({tag, "_m_mul_signed"},   64'(m_mul_signed), 64'd0);
        checkOutput({tag, "_m_multiplicand"}, m_multiplicand, 64'd0);
        checkOutput({tag, "_m_multiplier"},   m_multiplier, 64'd0);
    endtask

    // One complete uop: accept, wait for the result, hold it for 'hold' cycles, retire
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input int hold, input bit use_want,
                                 input logic [63:0] want);
        logic [2:0]  nop;
        logic [63:0] ea, eb, exp;
        logic [1:0]  exp_sig;
        bit          zero;
        int          cyc;
        int          start_cnt;
        nop     = (op > 3'd4) ? 3'd0 : op;
        ea      = (nop == 3'd4) ? {{32{a[31]}}, a[31:0]} : a;
        eb      = (nop == 3'd4) ? {{32{b[31]}}, b[31:0]} : b;
        zero    = (ea == 64'd0) || (eb == 64'd0);
        exp     = use_want ? want : ref_result(nop, a, b);
        exp_sig = (nop == 3'd2) ? 2'b10 : (nop == 3'd3) ? 2'b00 : 2'b11;

        cyc = 0;
        while (!ex_ready && cyc < 200) begin step(); cyc++; end
        checkOutput({tag, "_ex_ready_idle"}, 64'(ex_ready), 64'd1);
        start_cnt   = m_in_count;
        ex_valid    = 1'b1;
        ex_op       = op;
        ex_src1     = a;
        ex_src2     = b;
        wb_ready    = 1'b0;
        m_out_ready = 1'b1;
        step();
        ex_valid = 1'b0;
        ex_op    = 3'($urandom);
        ex_src1  = {$urandom, $urandom};
        ex_src2  = {$urandom, $urandom};
        checkOutput({tag, "_mul_signed"}, 64'(m_mul_signed), 64'(exp_sig));
        checkOutput({tag, "_mulw"}, 64'(m_mulw), 64'(nop == 3'd4));
        checkOutput({tag, "_multiplicand"}, m_multiplicand, ea);
        checkOutput({tag, "_multiplier"}, m_multiplier, eb);

        cyc = 0;
        while (!wb_valid && cyc < 200) begin step(); cyc++; end
        checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
        checkOutput({tag, "_latency"}, 64'(cyc), zero ? 64'd0 : 64'(mul_latency + 2));
        for (int i = 0; i <= hold; i++) begin
            checkOutput({tag, "_wb_data"}, wb_data, exp);
            checkOutput({tag, "_wb_valid_hold"}, 64'(wb_valid), 64'd1);
            checkOutput({tag, "_ex_ready_busy"}, 64'(ex_ready), 64'd0);
            if (i < hold) step();
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checkOutput({tag, "_wb_valid_retired"}, 64'(wb_valid), 64'd0);
        checkOutput({tag, "_ex_ready_after"}, 64'(ex_ready), 64'd1);
        checkOutput({tag, "_issue_count"}, 64'(m_in_count - start_cnt), zero ? 64'd0 : 64'd1);
    endtask

    initial begin
        int          cyc;
        int          start_cnt;
        bit          wb_seen;
        logic [2:0]  rop;
        logic [63:0] ra, rb;

        reset       = 1'b1;
        flush       = 1'b0;
        ex_valid    = 1'b0;
        ex_op       = 3'd0;
        ex_src1     = 64'd0;
        ex_src2     = 64'd0;
        wb_ready    = 1'b0;
        m_out_ready = 1'b1;

        // Reset state and combinational flush forwarding
        step();
        step();
        checkResetValues("reset");
        reset = 1'b0;
        step();
        flush = 1'b1;
        #1;
        checkOutput("m_flush_high", 64'(m_flush), 64'd1);
        flush = 1'b0;
        #1;
        checkOutput("m_flush_low", 64'(m_flush), 64'd0);
        step();

        // Directed operations from the test plan
        applyStimulus("mul_signed", 3'd0, 64'd3, -64'sd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        applyStimulus("mulhu",  3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1'b1, 64'h1);
        applyStimulus("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus("mulh",   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'h0);
        applyStimulus("mulw_a", 3'd4, 64'h7FFF_FFFF, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus("mulw_b", 3'd4, 64'h1_0000_0003, 64'd5, 0, 1'b1, 64'hF);
        applyStimulus("zero_bypass", 3'd0, 64'd0, 64'd7, 5, 1'b1, 64'd0);

        // Flush while the multiplier is busy; the later uop must ignore the stale pulse
        start_cnt = m_in_count;
        ex_valid = 1'b1; ex_op = 3'd0; ex_src1 = 64'd5; ex_src2 = 64'd5;
        step();
        ex_valid = 1'b0;
        step();
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("drain_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("drain_ex_ready", 64'(ex_ready), 64'd0);
        checkOutput("drain_issue_count", 64'(m_in_count - start_cnt), 64'd1);
        wb_seen = 1'b0;
        cyc = 0;
        while (!m_out_valid && cyc < 200) begin
            if (wb_valid) wb_seen = 1'b1;
            step();
            cyc++;
        end
        checkOutput("drain_pulse_seen", 64'(m_out_valid), 64'd1);
        step();
        checkOutput("drain_no_wb_valid", 64'(wb_seen | wb_valid), 64'd0);
        checkOutput("drain_done_ex_ready", 64'(ex_ready), 64'd1);
        applyStimulus("after_drain", 3'd0, 64'd6, 64'd7, 0, 1'b1, 64'd42);

        // Flush in the same cycle as the result pulse
        ex_valid = 1'b1; ex_op = 3'd0; ex_src1 = 64'd9; ex_src2 = 64'd9;
        step();
        ex_valid = 1'b0;
        cyc = 0;
        while (!m_out_valid && cyc < 200) begin step(); cyc++; end
        checkOutput("pulse_flush_seen", 64'(m_out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("pulse_flush_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("pulse_flush_ex_ready", 64'(ex_ready), 64'd1);

        // Flush while the result is waiting for writeback
        ex_valid = 1'b1; ex_op = 3'd0; ex_src1 = 64'd0; ex_src2 = 64'd5;
        step();
        ex_valid = 1'b0;
        checkOutput("done_flush_pre", 64'(wb_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("done_flush_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("done_flush_ex_ready", 64'(ex_ready), 64'd1);

        // Flush in REQ while the multiplier is not ready: nothing may be issued
        start_cnt = m_in_count;
        m_out_ready = 1'b0;
        ex_valid = 1'b1; ex_op = 3'd0; ex_src1 = 64'd4; ex_src2 = 64'd4;
        step();
        ex_valid = 1'b0;
        checkOutput("req_stall_in_valid", 64'(m_in_valid), 64'd0);
        checkOutput("req_stall_ex_ready", 64'(ex_ready), 64'd0);
        m_out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("req_flush_in_valid", 64'(m_in_valid), 64'd0);
        step();
        flush = 1'b0;
        checkOutput("req_flush_ex_ready", 64'(ex_ready), 64'd1);
        checkOutput("req_flush_issue_count", 64'(m_in_count - start_cnt), 64'd0);

        // Reset in WAIT returns every output to its reset value immediately
        ex_valid = 1'b1; ex_op = 3'd2; ex_src1 = 64'd11; ex_src2 = 64'd13;
        step();
        ex_valid = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        #1;
        checkResetValues("reset_wait");
        step();
        reset = 1'b0;
        step();

        // Randomised uops with varying multiplier latency and writeback backpressure
        for (int n = 0; n < 24; n++) begin
            mul_latency = $urandom_range(1, 40);
            rop = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            rb = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = 64'($signed(32'($urandom_range(0, 200)) - 32'sd100));
            applyStimulus("random", rop, ra, rb, $urandom_range(0, 3), 1'b0, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule
